// File: rtl/word_serializer_tx.sv
// -----------------------------------------------------------------------------
// word_serializer_tx
//   Sending end of the word serial link. Takes WORD_W-bit words on a
//   valid/ready handshake and shifts them out one bit per bit_en cycle. It
//   drives a frame strobe and a last-bit marker so that the receiving
//   deserializer can rebuild the words.
//
//   Optional feature: define PARITY_EN before compiling to append one
//   even-parity bit (XOR of the data bits) after each word. ser_last then
//   marks the parity bit and a frame is WORD_W+1 bits long.
//
// Parameters
//   WORD_W     data bits per word (>= 2)
//   MSB_FIRST  1: bit WORD_W-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word
//   in_ready   transmitter takes a word this cycle
//   in_data    word, sampled when in_valid && in_ready
//   bit_en     bit-rate enable; serial state advances only when 1
//   ser_data   serial bit
//   ser_frame  1 while ser_data carries a frame bit
//   ser_last   1 on the final bit of a frame
// -----------------------------------------------------------------------------
module word_serializer_tx #(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              bit_en,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              ser_last
);

  localparam int              CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               cur_bit;
  logic [WORD_W-1:0]  shifted;

`ifdef PARITY_EN
  logic               parity_q, parity_d;
`endif

  // The bit on the wire always sits at the leading end of the shift register.
  assign cur_bit = MSB_FIRST ? shreg_q[WORD_W-1] : shreg_q[0];
  assign shifted = MSB_FIRST ? {shreg_q[WORD_W-2:0], 1'b0}
                             : {1'b0, shreg_q[WORD_W-1:1]};

  assign ser_frame = (state_q != IDLE);

`ifdef PARITY_EN
  assign ser_data = ((state_q == SHIFT) && cur_bit) ||
                    ((state_q == PARITY) && parity_q);
  assign ser_last = (state_q == PARITY);
`else
  assign ser_data = (state_q == SHIFT) && cur_bit;
  assign ser_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

  // Ready also on the edge that consumes the final bit, so words can run
  // back to back without an idle cycle. Held low throughout reset.
  assign in_ready = rst_n && ((state_q == IDLE) || (ser_last && bit_en));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shreg_d = in_data;
      cnt_d   = '0;
`ifdef PARITY_EN
      parity_d = ^in_data;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (bit_en) begin
            if (cnt_q == LAST_CNT) begin
`ifdef PARITY_EN
              // Counter parks on the last index while the parity bit goes out.
              state_d = PARITY;
              shreg_d = '0;
`else
              state_d = IDLE;
              shreg_d = '0;
              cnt_d   = '0;
`endif
            end else begin
              shreg_d = shifted;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bit_en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            parity_d = 1'b0;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
